// File: rtl/axon_event_scheduler.sv
// Timestep event scheduler: on a tick, snapshots both cores' spike-axon vectors and streams
// every set bit as a (core, axon) event. Optional build macro SCHED_STRICT_PRIO_EN gives core 0 strict priority.
module axon_event_scheduler #(
    parameter int NUM_AXONS = 256,
    parameter int AXON_W    = $clog2(NUM_AXONS)
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    input  logic                 tick_i,
    input  logic [1:0]           core_en_i,
    input  logic [NUM_AXONS-1:0] spike_axon_0_i,
    input  logic [NUM_AXONS-1:0] spike_axon_1_i,
    output logic                 evt_valid_o,
    input  logic                 evt_ready_i,
    output logic                 evt_core_o,
    output logic [AXON_W-1:0]    evt_axon_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [AXON_W:0]      evt_cnt_0_o,
    output logic [AXON_W:0]      evt_cnt_1_o,
    output logic                 tick_ovr_o,
    input  logic                 ovr_clr_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [NUM_AXONS-1:0] PEND_ONE = {{(NUM_AXONS-1){1'b0}}, 1'b1};
    localparam logic [AXON_W:0]      CNT_ONE  = {{AXON_W{1'b0}}, 1'b1};

    state_t                 state_r;
    logic [NUM_AXONS-1:0]   pend_0_r, pend_1_r;
    logic                   evt_valid_r, evt_core_r, busy_r, done_r, tick_ovr_r;
    logic [AXON_W-1:0]      evt_axon_r;
    logic [AXON_W:0]        evt_cnt_0_r, evt_cnt_1_r;
`ifndef SCHED_STRICT_PRIO_EN
    logic                   rr_ptr_r;
`endif

    logic                   any_0_s, any_1_s, sel_s, xfer_s, load_s;
    logic [NUM_AXONS-1:0]   pend_sel_s, pend_nxt_s;
    logic [AXON_W-1:0]      axon_s;

    function automatic logic [AXON_W-1:0] lowest_idx(input logic [NUM_AXONS-1:0] v);
        logic [AXON_W-1:0] idx;
        idx = {AXON_W{1'b0}};
        for (int i = NUM_AXONS - 1; i >= 0; i--) begin
            if (v[i]) idx = AXON_W'(i);
        end
        return idx;
    endfunction

    // Arbitration, lowest-bit pick and handshake qualifiers
    always_comb begin
        any_0_s = |pend_0_r;
        any_1_s = |pend_1_r;
`ifdef SCHED_STRICT_PRIO_EN
        sel_s = ~any_0_s;
`else
        if (any_0_s && any_1_s) sel_s = rr_ptr_r;
        else                    sel_s = ~any_0_s;
`endif
        if (sel_s) pend_sel_s = pend_1_r;
        else       pend_sel_s = pend_0_r;
        // v & (v-1) drops exactly the lowest set bit, i.e. the one being loaded
        pend_nxt_s = pend_sel_s & (pend_sel_s - PEND_ONE);
        axon_s     = lowest_idx(pend_sel_s);
        xfer_s     = evt_valid_r & evt_ready_i;
        load_s     = (state_r == ST_SCAN) && (!evt_valid_r || evt_ready_i) && (any_0_s || any_1_s);
    end

    // Sequencer FSM with registered event, status and counter outputs
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_r     <= ST_IDLE;
            pend_0_r    <= {NUM_AXONS{1'b0}};
            pend_1_r    <= {NUM_AXONS{1'b0}};
            evt_valid_r <= 1'b0;
            evt_core_r  <= 1'b0;
            evt_axon_r  <= {AXON_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            evt_cnt_0_r <= {(AXON_W+1){1'b0}};
            evt_cnt_1_r <= {(AXON_W+1){1'b0}};
`ifndef SCHED_STRICT_PRIO_EN
            rr_ptr_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (tick_i) begin
                        pend_0_r    <= spike_axon_0_i & {NUM_AXONS{core_en_i[0]}};
                        pend_1_r    <= spike_axon_1_i & {NUM_AXONS{core_en_i[1]}};
                        evt_cnt_0_r <= {(AXON_W+1){1'b0}};
                        evt_cnt_1_r <= {(AXON_W+1){1'b0}};
                        busy_r      <= 1'b1;
                        state_r     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (xfer_s) begin
                        if (evt_core_r) evt_cnt_1_r <= evt_cnt_1_r + CNT_ONE;
                        else            evt_cnt_0_r <= evt_cnt_0_r + CNT_ONE;
                    end
                    if (load_s) begin
                        evt_valid_r <= 1'b1;
                        evt_core_r  <= sel_s;
                        evt_axon_r  <= axon_s;
                        if (sel_s) pend_1_r <= pend_nxt_s;
                        else       pend_0_r <= pend_nxt_s;
`ifndef SCHED_STRICT_PRIO_EN
                        if (any_0_s && any_1_s) rr_ptr_r <= ~sel_s;
`endif
                    end else if (xfer_s) begin
                        evt_valid_r <= 1'b0;
                    end
                    if (!any_0_s && !any_1_s && (!evt_valid_r || xfer_s)) begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    evt_valid_r <= 1'b0;
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overrun flag; a new overrun in the same cycle beats the clear
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i)                      tick_ovr_r <= 1'b0;
        else if (tick_i && state_r != ST_IDLE) tick_ovr_r <= 1'b1;
        else if (ovr_clr_i)                    tick_ovr_r <= 1'b0;
        else                                   tick_ovr_r <= tick_ovr_r;
    end

    assign evt_valid_o = evt_valid_r;
    assign evt_core_o  = evt_core_r;
    assign evt_axon_o  = evt_axon_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign evt_cnt_0_o = evt_cnt_0_r;
    assign evt_cnt_1_o = evt_cnt_1_r;
    assign tick_ovr_o  = tick_ovr_r;

endmodule
